// File: rtl/biu_fifo_1i2o_if.sv
// Handshake bundle for the single-push, dual-pop BIU FIFO.
// master = producer/consumer side, slave = FIFO side.
interface biu_fifo_1i2o_if #(
   parameter int AW = 4,
   parameter int DW = 32
);
   logic          din_valid;
   logic [DW-1:0] din;
   logic          allowIn;
   logic          dout0_valid;
   logic          dout1_valid;
   logic [DW-1:0] dout0;
   logic [DW-1:0] dout1;
   logic          pop0;
   logic          pop1;
   logic [AW:0]   count;
   logic          err;

   modport master (
      output din_valid, din, pop0, pop1,
      input  allowIn, dout0_valid, dout1_valid, dout0, dout1, count, err
   );

   modport slave (
      input  din_valid, din, pop0, pop1,
      output allowIn, dout0_valid, dout1_valid, dout0, dout1, count, err
   );
endinterface

// File: rtl/biu_fifo_1i2o.sv
// Single-push, dual-pop FIFO presenting the two oldest entries at once.
// Define BIU_FIFO_1I2O_ERR_EN to build the sticky pop-protocol error flag.
module biu_fifo_1i2o #(
   parameter int AW = 4,
   parameter int DW = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   biu_fifo_1i2o_if.slave       bus
);
   localparam int DEPTH = 1 << AW;

   logic [AW:0]   size_q;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_ptr_nx1;
   logic [DW-1:0] mem [DEPTH];

   logic          allow_in;
   logic          vld0;
   logic          vld1;
   logic          push;
   logic          p0;
   logic          p1;
   logic [1:0]    npop;

   // Flow control depends on registered occupancy only; a same-cycle pop never frees space.
   assign allow_in   = (size_q < (AW+1)'(DEPTH));
   assign vld0       = (size_q != '0);
   assign vld1       = (size_q > (AW+1)'(1));
   assign rd_ptr_nx1 = rd_ptr + 1'b1;

   assign push = bus.din_valid & allow_in;
   assign p0   = bus.pop0 & vld0;
   assign p1   = p0 & bus.pop1 & vld1;
   assign npop = {1'b0, p0} + {1'b0, p1};

   assign bus.allowIn     = allow_in;
   assign bus.dout0_valid = vld0;
   assign bus.dout1_valid = vld1;
   assign bus.dout0       = mem[rd_ptr];
   assign bus.dout1       = mem[rd_ptr_nx1];
   assign bus.count       = size_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         size_q <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         size_q <= size_q + (AW+1)'(push) - (AW+1)'(npop);
         rd_ptr <= rd_ptr + AW'(npop);
         if (push) begin
            wr_ptr      <= wr_ptr + 1'b1;
            mem[wr_ptr] <= bus.din;
         end
      end
   end

`ifdef BIU_FIFO_1I2O_ERR_EN
   logic err_q;
   logic err_hit;

   // Backpressure (din_valid while full) is normal operation, not an error.
   assign err_hit = (bus.pop0 & ~vld0)
                  | (bus.pop1 & ~bus.pop0)
                  | (bus.pop1 & bus.pop0 & ~vld1);

   always_ff @(posedge clk) begin
      if (rst)
         err_q <= 1'b0;
      else if (err_hit)
         err_q <= 1'b1;
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

endmodule
